// File: rtl/sc_spi_tgt_if.sv
// Register-side port of the SPI target: transmit word supply and
// received-word valid/ack handshake.
interface sc_spi_tgt_if #(
    parameter int MAXW = 32
);
    logic [MAXW-1:0] TXDATA;
    logic            TXREQ;
    logic [MAXW-1:0] RXDATA;
    logic            RXVALID;
    logic            RXACK;
    logic            RXOVR;

    modport master (output TXDATA, RXACK, input TXREQ, RXDATA, RXVALID, RXOVR);
    modport slave  (input TXDATA, RXACK, output TXREQ, RXDATA, RXVALID, RXOVR);
endinterface

// File: rtl/sc_spi_tgt.sv
// SPI target engine: oversamples SCK/CSB/MOSI in SYSCLK, deserialises MOSI,
// serialises a preloaded word onto MISO, hands words over via valid/ack.
module sc_spi_tgt #(
    parameter int MAXW = 32
) (
    input  logic        SYSCLK,
    input  logic        SYSRSTB,
    input  logic        CPOL,
    input  logic        CPHA,
    input  logic        BORDER,
    input  logic [5:0]  DWIDTH,
    output logic        XABORT,
    output logic        TGTBUSY,
    input  logic        SCK,
    input  logic        CSB,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_OE,
    sc_spi_tgt_if.slave rif
);
    localparam int CW = $clog2(MAXW + 1);

    typedef enum logic {tIDLE, tSHIFT} state_t;
    state_t state, state_nxt;

    logic [2:0]      sck_s, csb_s, mosi_s;
    logic            cpol_l, cpha_l, lsb_l;
    logic [CW-1:0]   w_in, w_l, bit_cnt;
    logic [MAXW-1:0] tx_sr, rx_sr, rx_data, ld_word, rx_word;
    logic            miso_q, tx_req, rx_valid, rx_ovr, xabort;
    logic            sck_rise, sck_fall, csb_rise, csb_fall;
    logic            lead, trail, samp, shft, done;

    // Pre-align so the first bit to transmit sits at the shift-out end.
    function automatic logic [MAXW-1:0] align(input logic [MAXW-1:0] d,
                                              input logic [CW-1:0] w, input logic lsb);
        return lsb ? d : (d << (CW'(MAXW) - w));
    endfunction

    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            sck_s  <= 3'b000;
            csb_s  <= 3'b111;
            mosi_s <= 3'b000;
        end else begin
            sck_s  <= {sck_s[1:0], SCK};
            csb_s  <= {csb_s[1:0], CSB};
            mosi_s <= {mosi_s[1:0], MOSI};
        end
    end

    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign sck_fall = ~sck_s[1] & sck_s[2];
    assign csb_rise = csb_s[1] & ~csb_s[2];
    assign csb_fall = ~csb_s[1] & csb_s[2];
    assign lead     = cpol_l ? sck_fall : sck_rise;
    assign trail    = cpol_l ? sck_rise : sck_fall;
    assign samp     = cpha_l ? trail : lead;
    assign shft     = cpha_l ? lead : trail;
    assign done     = (state == tSHIFT) && (bit_cnt == w_l);

    always_comb begin
        w_in = CW'(MAXW);
        if (DWIDTH != '0 && 32'(DWIDTH) <= MAXW) w_in = CW'(DWIDTH);
    end

    assign ld_word = align(rif.TXDATA, w_in, BORDER);
    // LSB-first words accumulate at the top of rx_sr; bring them down.
    assign rx_word = lsb_l ? (rx_sr >> (CW'(MAXW) - w_l)) : rx_sr;

    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) state <= tIDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            tIDLE:   if (csb_fall) state_nxt = tSHIFT;
            tSHIFT:  if (csb_rise) state_nxt = tIDLE;
            default: state_nxt = tIDLE;
        endcase
    end

    always_comb begin
        TGTBUSY = 1'b0;
        MISO_OE = 1'b0;
        if (state == tSHIFT) begin
            TGTBUSY = 1'b1;
            MISO_OE = 1'b1;
        end
    end

    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            w_l      <= CW'(MAXW);
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            miso_q   <= 1'b0;
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            xabort   <= 1'b0;
        end else begin
            tx_req <= 1'b0;
            rx_ovr <= 1'b0;
            xabort <= 1'b0;
            if (rif.RXACK) rx_valid <= 1'b0;
            if (state == tIDLE) begin
                if (csb_fall) begin
                    cpol_l  <= CPOL;
                    cpha_l  <= CPHA;
                    lsb_l   <= BORDER;
                    w_l     <= w_in;
                    bit_cnt <= '0;
                    rx_sr   <= '0;
                    tx_req  <= 1'b1;
                    // CPHA=0: the first bit must be on MISO before the first edge.
                    if (CPHA) begin
                        tx_sr  <= ld_word;
                        miso_q <= 1'b0;
                    end else begin
                        tx_sr  <= BORDER ? (ld_word >> 1) : (ld_word << 1);
                        miso_q <= BORDER ? ld_word[0] : ld_word[MAXW-1];
                    end
                end
            end else begin
                if (done) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                    rx_ovr   <= rx_valid & ~rif.RXACK;
                    bit_cnt  <= '0;
                    rx_sr    <= '0;
                    tx_sr    <= align(rif.TXDATA, w_l, lsb_l);
                    tx_req   <= 1'b1;
                end else if (!csb_rise) begin
                    if (samp) begin
                        rx_sr   <= lsb_l ? {mosi_s[2], rx_sr[MAXW-1:1]}
                                         : {rx_sr[MAXW-2:0], mosi_s[2]};
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                    if (shft) begin
                        miso_q <= lsb_l ? tx_sr[0] : tx_sr[MAXW-1];
                        tx_sr  <= lsb_l ? (tx_sr >> 1) : (tx_sr << 1);
                    end
                end
                if (csb_rise) begin
                    xabort <= (bit_cnt != '0) && !done;
                    miso_q <= 1'b0;
                end
            end
        end
    end

    assign MISO        = miso_q;
    assign XABORT      = xabort;
    assign rif.TXREQ   = tx_req;
    assign rif.RXDATA  = rx_data;
    assign rif.RXVALID = rx_valid;
    assign rif.RXOVR   = rx_ovr;
endmodule

// File: doc/sc_spi_tgt.md
Name: sc_spi_tgt

Overview:
SPI target (slave-side) protocol engine: the receiving end of the SPI link driven by the team's SPI initiator engine.
- Oversamples external SCK/CSB/MOSI in the SYSCLK domain.
- Deserialises MOSI into words and serialises a preloaded transmit word onto MISO.
- Presents completed words to a register block through a valid/ack handshake.
- Sits between the SPI pads and the target-side register interface.

Parameters:
MAXW, 32, maximum word width in bits (shift register and data-port width)

Ports:
SYSCLK  input  1  system clock
SYSRSTB  input  1  asynchronous active-low reset
CPOL  input  1  clock polarity
CPHA  input  1  clock phase
BORDER  input  1  bit order: 0 = MSB first, 1 = LSB first
DWIDTH  input  6  word width in bits; 0 or >MAXW means MAXW
TXDATA  input  MAXW  next word to shift out on MISO
TXREQ  output  1  one-cycle pulse: TXDATA sampled; supply the next word
RXDATA  output  MAXW  last received word, right-aligned
RXVALID  output  1  RXDATA holds an unacknowledged word
RXACK  input  1  clears RXVALID
RXOVR  output  1  one-cycle pulse: a word completed while RXVALID=1
XABORT  output  1  one-cycle pulse: CSB rose mid-word
TGTBUSY  output  1  CSB asserted (synchronised)
SCK  input  1  SPI clock (async)
CSB  input  1  chip select, active low (async)
MOSI  input  1  serial data in (async)
MISO  output  1  serial data out
MISO_OE  output  1  MISO output enable

Behaviour:
- Reset values:
  - RXDATA=0, RXVALID=0, TXREQ=0, RXOVR=0, XABORT=0, TGTBUSY=0, MISO=0, MISO_OE=0.
  - Synchronisers: CSB=1, SCK=0.
  - State = tIDLE.
- Synchronisation:
  - SCK, CSB, MOSI each pass through 2 flops, then 1 history flop for edge detect.
  - Pin-to-internal-event latency is 3 SYSCLK cycles.
  - SCK high and low phases must each be ≥4 SYSCLK periods.
- Edge definitions:
  - Leading SCK edge = rising if CPOL=0, falling if CPOL=1; trailing edge is the opposite.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Shift edge = the other one.
- tIDLE (synced CSB high):
  - MISO_OE=0.
  - On synced CSB fall, in the same cycle:
    - latch CPOL/CPHA/BORDER/DWIDTH;
    - load shift-out register from TXDATA and pulse TXREQ;
    - clear bit counter; TGTBUSY=1; MISO_OE=1;
    - go to tSHIFT.
  - If CPHA=0, drive the first data bit on MISO immediately.
- tSHIFT:
  - Sample edge: shift synced MOSI into the receive register at the end selected by BORDER; increment bit counter.
  - Shift edge: advance MISO to the next bit. With CPHA=1 the first bit is also driven on the first leading edge.
  - When the counter reaches the width, one cycle after the last sample edge:
    - RXDATA <= received word, upper unused bits zero;
    - if RXVALID was already 1, pulse RXOVR (RXDATA is overwritten);
    - RXVALID=1;
    - clear counter, reload the shift-out register from TXDATA, pulse TXREQ;
    - stay in tSHIFT for back-to-back words.
  - On synced CSB rise:
    - if counter≠0, pulse XABORT and discard the partial word (RXDATA, RXVALID unchanged);
    - TGTBUSY=0, MISO_OE=0;
    - go to tIDLE.
- Config latched at CSB fall stays fixed until CSB rises; changes to the inputs mid-select are ignored.
- Handshake:
  - RXACK while RXVALID=1 clears RXVALID next cycle.
  - If RXACK coincides with word completion, completion wins: RXVALID stays 1 and RXOVR does not pulse.
- MISO bit order:
  - MSB first: bit DWIDTH-1 down to bit 0.
  - LSB first: bit 0 up to bit DWIDTH-1.
- SCK edges while CSB is high are ignored.
- Asserting SYSRSTB mid-word immediately returns all outputs to reset values and discards the partial word; no XABORT pulse.

Test Plan:
- Mode 0, MSB first, DWIDTH=8, TXDATA=0x3C; initiator sends 0xA5 -> RXDATA=0x000000A5, RXVALID=1; MISO bits observed 0,0,1,1,1,1,0,0; TXREQ pulses at CSB fall and after bit 8.
- Mode 3, LSB first, DWIDTH=16, TXDATA=0x1234; initiator sends 0xBEEF -> RXDATA=0xBEEF; initiator captures 0x1234.
- CSB held low for 2×8 bits (0x11 then 0x22), RXACK issued between words; TXDATA changed to 0x55 after the first TXREQ -> two RXVALID events with 0x11 then 0x22; second MISO word is 0x55; no RXOVR.
- Same two words with no RXACK -> RXOVR pulses once; RXDATA=0x22; RXVALID stays 1.
- CSB rises after 5 of 8 bits -> XABORT one-cycle pulse; RXVALID unchanged; MISO_OE=0; the next full transfer of 0x5A is received correctly.
- SYSRSTB asserted after 3 bits, then released and a full 0xC3 transfer run -> all outputs at reset values during reset, no XABORT; subsequent RXDATA=0xC3.
